imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory the CPU fetches from. It accepts a byte stream, assembles 32-bit instruction words, writes them to consecutive word addresses from 0, and validates a trailing XOR checksum. It holds the CPU in reset for the whole load and releases it only after a good checksum.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction-memory loader. Consumes a byte stream, assembles
//   big-endian 32-bit words, writes them to consecutive word addresses
//   starting at 0, then compares one trailing byte against the running XOR
//   of every payload byte. The CPU is held in reset until a load completes
//   with a matching checksum.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   start          one-cycle pulse; accepted only in IDLE, DONE or ERROR
//   word_count     words to load, sampled on an accepted start; saturates
//                  at 2^ADDR_WIDTH
//   in_valid/in_data/in_ready  byte stream handshake (transfer when both high)
//   mem_we/mem_addr/mem_din    registered instruction-memory write port
//   cpu_rst        CPU reset, low only in DONE
//   busy           high in LOAD and CHECK
//   done / error   checksum good / checksum bad
module imem_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Clamp a requested word count to the size of the instruction memory.
  function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] cnt);
    return (cnt > MAX_WORDS) ? MAX_WORDS : cnt;
  endfunction

  state_t                state;
  state_t                state_nxt;

  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_p0;
  logic [7:0]            checksum;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [31:0]           din_p1;

  logic                  start_ok;
  logic                  load_accept;
  logic                  word_complete;
  logic [ADDR_WIDTH:0]   start_count;

  // A restart is only meaningful once the previous load has finished.
  assign start_ok      = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                   (state == ST_ERROR));
  assign load_accept   = (state == ST_LOAD) && in_valid;
  assign word_complete = load_accept && (byte_cnt == 2'd3);
  assign start_count   = sat_count(word_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst   = 1'b1;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        done    = (state == ST_DONE);
        error   = (state == ST_ERROR);
        cpu_rst = (state != ST_DONE);
        if (start) begin
          state_nxt = (start_count == '0) ? ST_CHECK : ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Leave on the edge that completes the final word; its write
        // pulse then lines up with the first CHECK cycle.
        if (in_valid && (byte_cnt == 2'd3) && (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1})) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = (in_data == checksum) ? ST_DONE : ST_ERROR;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stage p0: byte assembly, running checksum and load counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      addr_cnt  <= '0;
      byte_cnt  <= 2'd0;
      checksum  <= 8'h00;
    end else if (start_ok) begin
      remaining <= start_count;
      addr_cnt  <= '0;
      byte_cnt  <= 2'd0;
      checksum  <= 8'h00;
    end else if (load_accept) begin
      checksum <= checksum ^ in_data;
      byte_cnt <= byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // The first three bytes of a word shift in here; the fourth goes
  // straight into the write register.
  always_ff @(posedge clk) begin
    if (load_accept && (byte_cnt != 2'd3)) begin
      word_p0 <= {word_p0[15:0], in_data};
    end
  end

  // Stage p1: registered memory write. Reset clears the address and data
  // as well, since they are visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      vld_p1 <= word_complete;
      if (word_complete) begin
        addr_p1 <= addr_cnt;
        din_p1  <= {word_p0, in_data};
      end
    end
  end

  assign mem_we   = vld_p1;
  assign mem_addr = addr_p1;
  assign mem_din  = din_p1;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int AW   = 12;
  localparam int MAXW = 4096;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   word_count;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural model: what the loader must be doing, derived from the
  // bytes it has been given so far.
  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_DONE = 3, P_ERR = 4;
  int            m_phase  = P_IDLE;
  int            m_target = 0;
  int            m_w;
  bit            m_valid  = 1'b0;
  bit            m_in_rst = 1'b0;
  bit            m_we     = 1'b0;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_din;
  logic [7:0]    m_bytes[$];

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (m_bytes[i]) x ^= m_bytes[i];
    return x;
  endfunction

  always @(posedge clk) begin
    m_we     = 1'b0;
    m_in_rst = 1'b0;
    if (rst) begin
      m_phase  = P_IDLE;
      m_bytes.delete();
      m_valid  = 1'b1;
      m_in_rst = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        P_IDLE, P_DONE, P_ERR: begin
          if (start) begin
            m_target = (int'(word_count) > MAXW) ? MAXW : int'(word_count);
            m_bytes.delete();
            m_phase  = (m_target == 0) ? P_CHECK : P_LOAD;
          end
        end
        P_LOAD: begin
          if (in_valid) begin
            m_bytes.push_back(in_data);
            if (m_bytes.size() % 4 == 0) begin
              m_w    = m_bytes.size() / 4 - 1;
              m_we   = 1'b1;
              m_addr = m_w[AW-1:0];
              m_din  = {m_bytes[4*m_w], m_bytes[4*m_w+1], m_bytes[4*m_w+2], m_bytes[4*m_w+3]};
              if (m_bytes.size() == 4 * m_target) m_phase = P_CHECK;
            end
          end
        end
        default: begin
          if (in_valid) m_phase = (in_data == xor_all()) ? P_DONE : P_ERR;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("in_ready", in_ready, (m_phase == P_LOAD) || (m_phase == P_CHECK));
      check("busy",     busy,     (m_phase == P_LOAD) || (m_phase == P_CHECK));
      check("done",     done,     m_phase == P_DONE);
      check("error",    error,    m_phase == P_ERR);
      check("cpu_rst",  cpu_rst,  m_phase != P_DONE);
      check("mem_we",   mem_we,   m_we);
      if (m_we) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_din",  mem_din,  m_din);
      end
      if (m_in_rst) begin
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din",  mem_din,  0);
      end
    end
  end

  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_a.push_back(mem_addr);
      log_d.push_back(mem_din);
    end
  end

  bit noise_start = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic do_start(input int wc);
    start      = 1'b1;
    word_count = wc[AW:0];
    in_valid   = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gaps);
    bit acc;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (noise_start && ($urandom_range(3) == 0)) begin
        start      = 1'b1;
        word_count = (AW+1)'($urandom);
      end
      step();
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) check("in_ready_timeout", 0, 1);
  endtask

  task automatic send_all(input bq_t q, input int gaps);
    foreach (q[i]) send(q[i], gaps);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  bq_t two_words;
  bq_t q;

  initial begin
    rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = 8'h00;
    step();
    step();
    check("reset_cpu_rst",  cpu_rst,  1);
    check("reset_in_ready", in_ready, 0);
    check("reset_mem_we",   mem_we,   0);
    check("reset_done",     done,     0);
    check("reset_error",    error,    0);
    rst = 1'b0;
    step();

    // Two-word load; XOR of all eight payload bytes is 0x00.
    two_words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    clear_log();
    do_start(2);
    send_all(two_words, 0);
    check("good_cpu_rst_before_cks", cpu_rst, 1);
    send(8'h00, 0);
    check("good_done",         done,    1);
    check("good_cpu_rst_drop", cpu_rst, 0);
    check("model_xor_pin",     xor_all(), 8'h00);
    check("good_nwrites",      log_a.size(), 2);
    if (log_a.size() == 2) begin
      check("good_addr0", log_a[0], 0);
      check("good_din0",  log_d[0], 32'h12345678);
      check("good_addr1", log_a[1], 1);
      check("good_din1",  log_d[1], 32'h9ABCDEF0);
    end

    // Same stream with a wrong checksum.
    clear_log();
    do_start(2);
    send_all(two_words, 0);
    send(8'h09, 0);
    check("bad_error",   error,   1);
    check("bad_done",    done,    0);
    check("bad_cpu_rst", cpu_rst, 1);
    check("model_phase_pin", m_phase, P_ERR);
    check("bad_nwrites", log_a.size(), 2);
    if (log_d.size() == 2) check("bad_din1", log_d[1], 32'h9ABCDEF0);
    step();
    check("bad_cpu_rst_held", cpu_rst, 1);

    // Zero words, then a single-word restart.
    clear_log();
    do_start(0);
    check("zero_busy", busy, 1);
    send(8'h00, 0);
    check("zero_done",    done, 1);
    check("zero_nwrites", log_a.size(), 0);
    q = '{8'h00, 8'h00, 8'h00, 8'h13};
    do_start(1);
    send_all(q, 0);
    send(8'h13, 0);
    check("one_done",    done, 1);
    check("one_nwrites", log_a.size(), 1);
    if (log_a.size() == 1) begin
      check("one_addr", log_a[0], 0);
      check("one_din",  log_d[0], 32'h00000013);
    end

    // Stalls every other cycle plus a start pulse in the middle of the load.
    clear_log();
    do_start(1);
    send(8'hA1, 1);
    send(8'hB2, 1);
    start = 1'b1; word_count = 13'd5; step(); start = 1'b0;
    send(8'hC3, 1);
    send(8'hD4, 1);
    send(8'h04, 1);
    check("stall_done",    done, 1);
    check("stall_nwrites", log_a.size(), 1);
    if (log_a.size() == 1) begin
      check("stall_addr", log_a[0], 0);
      check("stall_din",  log_d[0], 32'hA1B2C3D4);
    end

    // Reset after three bytes of the second word.
    do_start(3);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_all(q, 0);
    clear_log();
    rst = 1'b1; step(); rst = 1'b0;
    check("abort_busy",     busy,     0);
    check("abort_in_ready", in_ready, 0);
    check("abort_mem_we",   mem_we,   0);
    check("abort_addr",     mem_addr, 0);
    for (int i = 0; i < 5; i++) step();
    check("abort_nwrites", log_a.size(), 0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start(1);
    send_all(q, 0);
    send(8'h44, 0);
    check("abort_reload_done", done, 1);
    check("abort_reload_n",    log_a.size(), 1);
    if (log_a.size() == 1) begin
      check("abort_reload_addr", log_a[0], 0);
      check("abort_reload_din",  log_d[0], 32'h11223344);
    end

    // Randomised loads with stalls, stray starts, bad checksums and aborts.
    noise_start = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int   wc, nb, abort_at, gaps;
      bit   good;
      logic [7:0] x, b;
      wc       = $urandom_range(0, 6);
      nb       = 4 * wc;
      good     = ($urandom_range(3) != 0);
      abort_at = (nb > 0 && $urandom_range(5) == 0) ? $urandom_range(0, nb - 1) : -1;
      x        = 8'h00;
      do_start(wc);
      for (int i = 0; i < nb; i++) begin
        if (i == abort_at) break;
        b    = 8'($urandom);
        x   ^= b;
        gaps = ($urandom_range(2) == 0) ? $urandom_range(1, 3) : 0;
        send(b, gaps);
      end
      if (abort_at >= 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rand_abort_idle", busy, 0);
        step();
      end else begin
        send(good ? x : (x ^ 8'($urandom_range(1, 255))), $urandom_range(0, 2));
        check("rand_done",  done,  good);
        check("rand_error", error, !good);
        for (int i = 0; i < $urandom_range(0, 3); i++) step();
      end
    end
    noise_start = 1'b0;

    // Oversized request saturates to the full memory and fills every address.
    begin
      logic [7:0] x, b;
      x = 8'h00;
      clear_log();
      do_start(8191);
      for (int i = 0; i < 4 * MAXW; i++) begin
        b  = 8'($urandom);
        x ^= b;
        send(b, 0);
      end
      send(x, 0);
      check("sat_done",    done, 1);
      check("sat_nwrites", log_a.size(), MAXW);
      if (log_a.size() == MAXW) check("sat_last_addr", log_a[MAXW-1], MAXW - 1);
    end

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
